// File: rtl/stopwatch.sv
// MM:SS stopwatch with run/pause, lap freeze and clear, counting in BCD on CE ticks.
// SAT picks overflow handling: saturate at 99:59 into FULL, or wrap to 00:00 and keep running.
module stopwatch #(
  parameter bit SAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] D3,
  output logic [3:0] D2,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       running,
  output logic       lap_hold,
  output logic       OVF
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

  state_t     state, state_nx;
  logic [3:0] live3, live2, live1, live0;
  logic [3:0] live3_nx, live2_nx, live1_nx, live0_nx;
  logic [3:0] lap3, lap2, lap1, lap0;
  logic [3:0] lap3_nx, lap2_nx, lap1_nx, lap0_nx;
  logic       hold_q, hold_nx;
  logic       ovf_q, ovf_nx;
  logic       at_max;

  assign at_max = (live3 == 4'd9) && (live2 == 4'd9) && (live1 == 4'd5) && (live0 == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      live3  <= 4'd0;
      live2  <= 4'd0;
      live1  <= 4'd0;
      live0  <= 4'd0;
      lap3   <= 4'd0;
      lap2   <= 4'd0;
      lap1   <= 4'd0;
      lap0   <= 4'd0;
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      live3  <= live3_nx;
      live2  <= live2_nx;
      live1  <= live1_nx;
      live0  <= live0_nx;
      lap3   <= lap3_nx;
      lap2   <= lap2_nx;
      lap1   <= lap1_nx;
      lap0   <= lap0_nx;
      hold_q <= hold_nx;
      ovf_q  <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    live3_nx = live3;
    live2_nx = live2;
    live1_nx = live1;
    live0_nx = live0;
    lap3_nx  = lap3;
    lap2_nx  = lap2;
    lap1_nx  = lap1;
    lap0_nx  = lap0;
    hold_nx  = hold_q;
    ovf_nx   = ovf_q;

    if (clear && state != RUN) begin
      state_nx = IDLE;
      live3_nx = 4'd0;
      live2_nx = 4'd0;
      live1_nx = 4'd0;
      live0_nx = 4'd0;
      lap3_nx  = 4'd0;
      lap2_nx  = 4'd0;
      lap1_nx  = 4'd0;
      lap0_nx  = 4'd0;
      hold_nx  = 1'b0;
      ovf_nx   = 1'b0;
    end else begin
      if (state == RUN && CE) begin
        if (at_max) begin
          ovf_nx = 1'b1;
          if (SAT) begin
            state_nx = FULL;
          end else begin
            live3_nx = 4'd0;
            live2_nx = 4'd0;
            live1_nx = 4'd0;
            live0_nx = 4'd0;
          end
        end else if (live0 != 4'd9) begin
          live0_nx = live0 + 4'd1;
        end else begin
          live0_nx = 4'd0;
          if (live1 != 4'd5) begin
            live1_nx = live1 + 4'd1;
          end else begin
            live1_nx = 4'd0;
            if (live2 != 4'd9) begin
              live2_nx = live2 + 4'd1;
            end else begin
              live2_nx = 4'd0;
              live3_nx = live3 + 4'd1;
            end
          end
        end
      end

      // Saturation into FULL outranks a same-cycle start_stop.
      if (start_stop && state_nx != FULL) begin
        case (state)
          IDLE:    state_nx = RUN;
          RUN:     state_nx = PAUSE;
          PAUSE:   state_nx = RUN;
          default: state_nx = state;
        endcase
      end

      if (lap) begin
        if (hold_q) begin
          hold_nx = 1'b0;
        end else if (state == RUN) begin
          lap3_nx = live3;
          lap2_nx = live2;
          lap1_nx = live1;
          lap0_nx = live0;
          hold_nx = 1'b1;
        end
      end
    end
  end

  assign D3       = hold_q ? lap3 : live3;
  assign D2       = hold_q ? lap2 : live2;
  assign D1       = hold_q ? lap1 : live1;
  assign D0       = hold_q ? lap0 : live0;
  assign running  = (state == RUN);
  assign lap_hold = hold_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_stopwatch.sv
// Drives a saturating and a wrapping stopwatch with the same inputs and compares both
// against a seconds-based reference model every cycle, plus fixed expected readings.
module tb_stopwatch;

  logic       clk = 1'b0;
  logic       reset, CE, start_stop, clear, lap;
  logic [3:0] s_d3, s_d2, s_d1, s_d0, w_d3, w_d2, w_d1, w_d0;
  logic       s_running, s_lap_hold, s_ovf, w_running, w_lap_hold, w_ovf;

  always #5 clk = ~clk;

  stopwatch #(.SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .CE(CE), .start_stop(start_stop), .clear(clear), .lap(lap),
    .D3(s_d3), .D2(s_d2), .D1(s_d1), .D0(s_d0),
    .running(s_running), .lap_hold(s_lap_hold), .OVF(s_ovf)
  );

  stopwatch #(.SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .CE(CE), .start_stop(start_stop), .clear(clear), .lap(lap),
    .D3(w_d3), .D2(w_d2), .D1(w_d1), .D0(w_d0),
    .running(w_running), .lap_hold(w_lap_hold), .OVF(w_ovf)
  );

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;
  localparam int MAX_SEC = 99 * 60 + 59;

  // Index 0 models the SAT=1 instance, index 1 the SAT=0 instance.
  int m_st[2];
  int m_live[2];
  int m_lap[2];
  bit m_hold[2];
  bit m_ovf[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    logic [3:0] a, b, c, d;
    a = 4'((secs / 60) / 10);
    b = 4'((secs / 60) % 10);
    c = 4'((secs % 60) / 10);
    d = 4'((secs % 60) % 10);
    return {a, b, c, d};
  endfunction

  function automatic logic [15:0] disp(input int i);
    return (i == 0) ? {s_d3, s_d2, s_d1, s_d0} : {w_d3, w_d2, w_d1, w_d0};
  endfunction

  task automatic model_step(input int i, input bit sat, input bit rst, input bit ce,
                            input bit ss, input bit clr, input bit lp);
    int nst;
    if (rst || (clr && m_st[i] != M_RUN)) begin
      m_st[i] = M_IDLE; m_live[i] = 0; m_lap[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
    end else begin
      nst = m_st[i];
      if (lp) begin
        if (m_hold[i]) m_hold[i] = 0;
        else if (m_st[i] == M_RUN) begin m_lap[i] = m_live[i]; m_hold[i] = 1; end
      end
      if (m_st[i] == M_RUN && ce) begin
        if (m_live[i] == MAX_SEC) begin
          m_ovf[i] = 1;
          if (sat) nst = M_FULL;
          else m_live[i] = 0;
        end else begin
          m_live[i] = m_live[i] + 1;
        end
      end
      if (ss && nst != M_FULL) begin
        if (m_st[i] == M_IDLE || m_st[i] == M_PAUSE) nst = M_RUN;
        else if (m_st[i] == M_RUN) nst = M_PAUSE;
      end
      m_st[i] = nst;
    end
  endtask

  task automatic compare_all();
    check("sat_disp", disp(0), m_hold[0] ? to_bcd(m_lap[0]) : to_bcd(m_live[0]));
    check("sat_running", s_running, m_st[0] == M_RUN);
    check("sat_lap_hold", s_lap_hold, m_hold[0]);
    check("sat_ovf", s_ovf, m_ovf[0]);
    check("wrap_disp", disp(1), m_hold[1] ? to_bcd(m_lap[1]) : to_bcd(m_live[1]));
    check("wrap_running", w_running, m_st[1] == M_RUN);
    check("wrap_lap_hold", w_lap_hold, m_hold[1]);
    check("wrap_ovf", w_ovf, m_ovf[1]);
  endtask

  task automatic cycle(input bit ce, input bit ss, input bit clr, input bit lp, input bit rst);
    @(negedge clk);
    CE = ce; start_stop = ss; clear = clr; lap = lp; reset = rst;
    @(posedge clk);
    model_step(0, 1'b1, rst, ce, ss, clr, lp);
    model_step(1, 1'b0, rst, ce, ss, clr, lp);
    #1;
    compare_all();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; CE = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_live[i] = 0; m_lap[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
    end

    cycle(1, 1, 1, 1, 1);
    check("rst_disp", disp(0), 16'h0000);
    check("rst_running", s_running, 1'b0);
    check("rst_lap_hold", s_lap_hold, 1'b0);
    check("rst_ovf", s_ovf, 1'b0);

    // Count to 01:15, passing the 00:59 -> 01:00 carry.
    cycle(0, 1, 0, 0, 0);
    for (int k = 1; k <= 75; k++) begin
      tick(1);
      if (k == 60) check("carry_0100", disp(0), 16'h0100);
    end
    check("run_0115", disp(0), 16'h0115);
    check("run_0115_running", s_running, 1'b1);

    tick(599 - 75);
    check("at_0959", disp(0), 16'h0959);
    tick(1);
    check("carry_1000", disp(0), 16'h1000);

    tick(MAX_SEC - 600);
    check("sat_9959", disp(0), 16'h9959);
    check("wrap_9959", disp(1), 16'h9959);
    tick(1);
    check("sat_hold", disp(0), 16'h9959);
    check("sat_ovf_set", s_ovf, 1'b1);
    check("sat_full", s_running, 1'b0);
    check("wrap_zero", disp(1), 16'h0000);
    check("wrap_ovf_set", w_ovf, 1'b1);
    check("wrap_running", w_running, 1'b1);
    tick(1);
    check("wrap_0001", disp(1), 16'h0001);
    check("sat_still", disp(0), 16'h9959);
    cycle(0, 1, 0, 0, 0);
    check("full_ss_ignored", s_running, 1'b0);
    check("full_ss_disp", disp(0), 16'h9959);
    cycle(0, 0, 1, 0, 0);
    check("clr_full_disp", disp(0), 16'h0000);
    check("clr_full_ovf", s_ovf, 1'b0);
    check("clr_full_idle", s_running, 1'b0);

    // Lap freeze at 00:20 while counting continues.
    cycle(0, 1, 0, 0, 0);
    tick(20);
    cycle(1, 0, 0, 1, 0);
    check("lap_frozen", disp(0), 16'h0020);
    check("lap_hold_set", s_lap_hold, 1'b1);
    tick(10);
    check("lap_still", disp(0), 16'h0020);
    cycle(0, 0, 0, 1, 0);
    check("lap_release", disp(0), 16'h0031);
    check("lap_hold_clr", s_lap_hold, 1'b0);

    // Tick plus start_stop, pause behaviour, clear ignored in RUN, reset mid-run.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    tick(5);
    cycle(1, 1, 0, 0, 0);
    check("pause_0006", disp(0), 16'h0006);
    check("pause_state", s_running, 1'b0);
    tick(1);
    check("pause_no_count", disp(0), 16'h0006);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("clr_run_ignored", disp(0), 16'h0006);
    check("clr_run_running", s_running, 1'b1);
    tick(3);
    cycle(1, 0, 0, 0, 1);
    check("rst_mid_run", disp(0), 16'h0000);
    check("rst_mid_idle", s_running, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 6,
            $urandom_range(99, 0) < 2, $urandom_range(99, 0) < 6,
            $urandom_range(999, 0) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
